// File: rtl/rv32i_types.sv
// Shared RV32I out-of-order types: decode info, CDB broadcast and the generic
// reservation-station entry used by every functional-unit station.
package rv32i_types;

    localparam int NUM_ADD_REGISTERS      = 4;
    localparam int NUM_MULTIPLY_REGISTERS = 2;
    localparam int NUM_DIVIDE_REGISTERS   = 2;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        funct7_b5;
        logic [31:0] imm;
    } decode_info_t;

    typedef struct packed {
        logic        valid;
        logic [5:0]  rob_entry;
        logic [5:0]  pd_s;
        logic [4:0]  rd_s;
        logic [31:0] data;
    } cdb_t;

    typedef struct packed {
        logic         busy;
        logic         ps1_v;
        logic [5:0]   ps1;
        logic         ps2_v;
        logic [5:0]   ps2;
        logic [5:0]   pd;
        logic [4:0]   rd;
        logic [5:0]   rob_entry;
        decode_info_t decode_info;
    } rs_entry_t;

    // Physical register 0 is hardwired zero, so it never needs a wakeup.
    function automatic logic operands_ready(input rs_entry_t e);
        return (e.ps1_v || (e.ps1 == '0)) && (e.ps2_v || (e.ps2 == '0));
    endfunction

endpackage

// File: rtl/rs_wakeup_cmp.sv
// Applies all CDB broadcasts of one cycle to a single station entry.
import rv32i_types::*;

module rs_wakeup_cmp #(
    parameter int NUM_CDB = 1
) (
    input  rs_entry_t entry_i,
    input  cdb_t      cdb_i [NUM_CDB],
    output rs_entry_t entry_o
);

    always_comb begin
        entry_o = entry_i;
        for (int k = 0; k < NUM_CDB; k++) begin
            if (cdb_i[k].valid && (cdb_i[k].pd_s != '0)) begin
                if (!entry_i.ps1_v && (cdb_i[k].pd_s == entry_i.ps1)) entry_o.ps1_v = 1'b1;
                if (!entry_i.ps2_v && (cdb_i[k].pd_s == entry_i.ps2)) entry_o.ps2_v = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reservation_station_param.sv
// Compacting, age-ordered reservation station: slot 0 is always the oldest entry,
// the oldest ready entry issues and younger slots shift down to close the gap.
import rv32i_types::*;

module reservation_station_param #(
    parameter int DEPTH   = NUM_ADD_REGISTERS,
    parameter int NUM_CDB = 1,
    localparam int CW     = $clog2(DEPTH + 1),
    localparam int IW     = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          dispatch_valid,
    output logic          dispatch_ready,
    input  rs_entry_t     dispatch_entry,
    input  cdb_t          cdb_i [NUM_CDB],
    output logic          issue_valid,
    input  logic          issue_ready,
    output rs_entry_t     issue_entry,
    output logic [CW-1:0] count
);

    rs_entry_t     slots_q [DEPTH];
    rs_entry_t     slots_d [DEPTH];
    rs_entry_t     woken   [DEPTH];
    rs_entry_t     disp_in;
    rs_entry_t     disp_woken;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] tail;
    logic [IW-1:0] sel_idx;
    logic          any_ready;
    logic          do_issue;
    logic          do_disp;

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot_wakeup
        rs_wakeup_cmp #(.NUM_CDB(NUM_CDB)) u_wakeup (
            .entry_i (slots_q[g]),
            .cdb_i   (cdb_i),
            .entry_o (woken[g])
        );
    end

    always_comb begin
        disp_in      = dispatch_entry;
        disp_in.busy = 1'b1;
    end

    // Dispatch bypass: a broadcast in the dispatch cycle must not be missed.
    rs_wakeup_cmp #(.NUM_CDB(NUM_CDB)) u_disp_wakeup (
        .entry_i (disp_in),
        .cdb_i   (cdb_i),
        .entry_o (disp_woken)
    );

    // Descending scan so the lowest (oldest) ready slot wins.
    always_comb begin
        any_ready = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (slots_q[i].busy && operands_ready(slots_q[i])) begin
                any_ready = 1'b1;
                sel_idx   = IW'(i);
            end
        end
    end

    assign dispatch_ready = (count_q < CW'(DEPTH));
    assign issue_valid    = !flush && any_ready;
    assign issue_entry    = slots_q[sel_idx];
    assign count          = count_q;
    assign do_issue       = issue_valid && issue_ready;
    assign do_disp        = dispatch_valid && dispatch_ready;

    always_comb begin
        tail = do_issue ? (count_q - CW'(1)) : count_q;
        for (int i = 0; i < DEPTH; i++) slots_d[i] = woken[i];
        if (do_issue) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (i >= int'(sel_idx)) slots_d[i] = woken[i + 1];
            end
            slots_d[DEPTH - 1] = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (do_disp && (i == int'(tail))) slots_d[i] = disp_woken;
        end

        count_d = count_q;
        if (do_disp && !do_issue)      count_d = count_q + CW'(1);
        else if (!do_disp && do_issue) count_d = count_q - CW'(1);

        // Flush overrides both dispatch and issue.
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) slots_d[i].busy = 1'b0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) slots_q[i] <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) slots_q[i] <= slots_d[i];
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_reservation_station_param.sv
// Table-driven bench for reservation_station_param (DEPTH=4, NUM_CDB=2) with an
// issue scoreboard fed from the table and drained by a handshake monitor.
import rv32i_types::*;

module tb_reservation_station_param;

    localparam int DEPTH   = 4;
    localparam int NUM_CDB = 2;
    localparam int NVEC    = 27;

    typedef struct {
        logic       dv;
        logic [5:0] ps1;
        logic       v1;
        logic [5:0] ps2;
        logic       v2;
        logic [5:0] rob;
        logic       c0v;
        logic [5:0] c0;
        logic       c1v;
        logic [5:0] c1;
        logic       ir;
        logic       fl;
        logic [2:0] ecnt;
        logic       edrdy;
        logic       eiv;
        logic [5:0] erob;
        logic       ev1;
        logic       ev2;
    } vec_t;

    typedef struct {
        logic [5:0] rob;
        logic       v1;
        logic       v2;
    } sb_t;

    logic      clk;
    logic      rst_n;
    logic      flush;
    logic      dispatch_valid;
    logic      dispatch_ready;
    rs_entry_t dispatch_entry;
    cdb_t      cdb_i [NUM_CDB];
    logic      issue_valid;
    logic      issue_ready;
    rs_entry_t issue_entry;
    logic [2:0] count;

    int   tests_run = 0;
    int   tests_failed = 0;
    vec_t vecs [NVEC];
    sb_t  sb_q [$];

    reservation_station_param #(.DEPTH(DEPTH), .NUM_CDB(NUM_CDB)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .dispatch_valid (dispatch_valid),
        .dispatch_ready (dispatch_ready),
        .dispatch_entry (dispatch_entry),
        .cdb_i          (cdb_i),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .issue_entry    (issue_entry),
        .count          (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic rs_entry_t mk_entry(input logic [5:0] ps1, input logic v1,
                                           input logic [5:0] ps2, input logic v2,
                                           input logic [5:0] rob);
        rs_entry_t e;
        e                 = '0;
        e.ps1             = ps1;
        e.ps1_v           = v1;
        e.ps2             = ps2;
        e.ps2_v           = v2;
        e.pd              = rob ^ 6'h20;
        e.rd              = rob[4:0];
        e.rob_entry       = rob;
        e.decode_info.imm = {26'b0, rob};
        return e;
    endfunction

    function automatic vec_t mk(input logic dv, input logic [5:0] ps1, input logic v1,
                                input logic [5:0] ps2, input logic v2, input logic [5:0] rob,
                                input logic c0v, input logic [5:0] c0,
                                input logic c1v, input logic [5:0] c1,
                                input logic ir, input logic fl,
                                input logic [2:0] ecnt, input logic edrdy, input logic eiv,
                                input logic [5:0] erob, input logic ev1, input logic ev2);
        vec_t v;
        v.dv = dv;  v.ps1 = ps1; v.v1 = v1; v.ps2 = ps2; v.v2 = v2; v.rob = rob;
        v.c0v = c0v; v.c0 = c0; v.c1v = c1v; v.c1 = c1; v.ir = ir; v.fl = fl;
        v.ecnt = ecnt; v.edrdy = edrdy; v.eiv = eiv; v.erob = erob; v.ev1 = ev1; v.ev2 = ev2;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        @(negedge clk);
        dispatch_valid  = v.dv;
        dispatch_entry  = mk_entry(v.ps1, v.v1, v.ps2, v.v2, v.rob);
        cdb_i[0]        = '0;
        cdb_i[0].valid  = v.c0v;
        cdb_i[0].pd_s   = v.c0;
        cdb_i[1]        = '0;
        cdb_i[1].valid  = v.c1v;
        cdb_i[1].pd_s   = v.c1;
        issue_ready     = v.ir;
        flush           = v.fl;
        if (v.ir && v.eiv) sb_q.push_back('{rob: v.erob, v1: v.ev1, v2: v.ev2});
        #1;
        checkOutput($sformatf("vec%0d count", idx), 32'(count), 32'(v.ecnt));
        checkOutput($sformatf("vec%0d dispatch_ready", idx), 32'(dispatch_ready), 32'(v.edrdy));
        checkOutput($sformatf("vec%0d issue_valid", idx), 32'(issue_valid), 32'(v.eiv));
        if (v.eiv) checkOutput($sformatf("vec%0d issue_rob", idx), 32'(issue_entry.rob_entry), 32'(v.erob));
    endtask

    // Scoreboard drain: every accepted issue must match the next expected entry.
    always @(negedge clk) begin
        sb_t exp_e;
        #2;
        if (rst_n && issue_valid && issue_ready) begin
            if (sb_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL unexpected_issue: got rob %0h, expected no issue", issue_entry.rob_entry);
            end else begin
                exp_e = sb_q.pop_front();
                checkOutput("sb issue_rob", 32'(issue_entry.rob_entry), 32'(exp_e.rob));
                checkOutput("sb issue_ps1_v", 32'(issue_entry.ps1_v), 32'(exp_e.v1));
                checkOutput("sb issue_ps2_v", 32'(issue_entry.ps2_v), 32'(exp_e.v2));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n          = 1'b0;
        flush          = 1'b0;
        dispatch_valid = 1'b0;
        dispatch_entry = '0;
        cdb_i[0]       = '0;
        cdb_i[1]       = '0;
        issue_ready    = 1'b0;

        //            dv ps1 v1 ps2 v2 rob  c0v c0 c1v c1  ir fl  cnt rdy iv rob ev1 ev2
        vecs[0]  = mk(0, 0,  0, 0, 0, 0,   0, 0,  0, 0,   0, 0,  0, 1, 0, 0,  0, 0);
        vecs[1]  = mk(1, 10, 0, 0, 0, 1,   0, 0,  0, 0,   0, 0,  0, 1, 0, 0,  0, 0);
        vecs[2]  = mk(1, 11, 0, 0, 0, 2,   0, 0,  0, 0,   0, 0,  1, 1, 0, 0,  0, 0);
        vecs[3]  = mk(1, 12, 0, 0, 0, 3,   0, 0,  0, 0,   0, 0,  2, 1, 0, 0,  0, 0);
        vecs[4]  = mk(1, 13, 0, 0, 0, 4,   0, 0,  0, 0,   0, 0,  3, 1, 0, 0,  0, 0);
        vecs[5]  = mk(0, 0,  0, 0, 0, 0,   0, 0,  0, 0,   0, 0,  4, 0, 0, 0,  0, 0);
        vecs[6]  = mk(1, 40, 0, 0, 0, 9,   0, 0,  0, 0,   0, 0,  4, 0, 0, 0,  0, 0);
        vecs[7]  = mk(0, 0,  0, 0, 0, 0,   0, 0,  1, 12,  1, 0,  4, 0, 0, 0,  0, 0);
        vecs[8]  = mk(0, 0,  0, 0, 0, 0,   0, 0,  0, 0,   1, 0,  4, 0, 1, 3,  1, 0);
        vecs[9]  = mk(1, 14, 0, 0, 0, 5,   0, 0,  0, 0,   0, 0,  3, 1, 0, 0,  0, 0);
        vecs[10] = mk(0, 0,  0, 0, 0, 0,   1, 11, 1, 14,  0, 0,  4, 0, 0, 0,  0, 0);
        vecs[11] = mk(0, 0,  0, 0, 0, 0,   0, 0,  0, 0,   0, 0,  4, 0, 1, 2,  1, 0);
        vecs[12] = mk(0, 0,  0, 0, 0, 0,   0, 0,  0, 0,   0, 0,  4, 0, 1, 2,  1, 0);
        vecs[13] = mk(0, 0,  0, 0, 0, 0,   0, 0,  0, 0,   0, 0,  4, 0, 1, 2,  1, 0);
        vecs[14] = mk(0, 0,  0, 0, 0, 0,   0, 0,  0, 0,   1, 0,  4, 0, 1, 2,  1, 0);
        vecs[15] = mk(0, 0,  0, 0, 0, 0,   0, 0,  0, 0,   1, 0,  3, 1, 1, 5,  1, 0);
        vecs[16] = mk(1, 20, 1, 7, 0, 6,   1, 7,  0, 0,   0, 0,  2, 1, 0, 0,  0, 0);
        vecs[17] = mk(0, 0,  0, 0, 0, 0,   0, 0,  0, 0,   1, 0,  3, 1, 1, 6,  1, 1);
        vecs[18] = mk(1, 0,  0, 0, 0, 7,   1, 0,  0, 0,   0, 0,  2, 1, 0, 0,  0, 0);
        vecs[19] = mk(0, 0,  0, 0, 0, 0,   0, 0,  1, 0,   0, 0,  3, 1, 1, 7,  0, 0);
        vecs[20] = mk(0, 0,  0, 0, 0, 0,   0, 0,  0, 0,   1, 0,  3, 1, 1, 7,  0, 0);
        vecs[21] = mk(1, 30, 1, 0, 1, 8,   0, 0,  0, 0,   0, 0,  2, 1, 0, 0,  0, 0);
        vecs[22] = mk(1, 0,  1, 0, 1, 9,   0, 0,  0, 0,   1, 1,  3, 1, 0, 0,  0, 0);
        vecs[23] = mk(0, 0,  0, 0, 0, 0,   0, 0,  0, 0,   0, 0,  0, 1, 0, 0,  0, 0);
        vecs[24] = mk(1, 0,  1, 0, 1, 10,  0, 0,  0, 0,   0, 0,  0, 1, 0, 0,  0, 0);
        vecs[25] = mk(0, 0,  0, 0, 0, 0,   0, 0,  0, 0,   1, 0,  1, 1, 1, 10, 1, 1);
        vecs[26] = mk(0, 0,  0, 0, 0, 0,   0, 0,  0, 0,   0, 0,  0, 1, 0, 0,  0, 0);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) applyStimulus(vecs[i], i);

        // Reset mid-operation must discard entries without waiting for a clock edge.
        applyStimulus(mk(1, 0, 1, 0, 1, 11, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), 100);
        applyStimulus(mk(1, 50, 0, 0, 0, 12, 0, 0, 0, 0, 0, 0, 1, 1, 1, 11, 1, 1), 101);
        @(negedge clk);
        dispatch_valid = 1'b0;
        #1;
        checkOutput("pre_reset count", 32'(count), 32'd2);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset count", 32'(count), 32'd0);
        checkOutput("async_reset issue_valid", 32'(issue_valid), 32'd0);
        checkOutput("async_reset dispatch_ready", 32'(dispatch_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0), 102);
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), 103);

        @(negedge clk);
        #3;
        checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
